// File: rtl/rc5_rotator_pipe_if.sv
// Handshake bundle for rc5_rotator_pipe: an input word stream carrying the rotate
// control, and the rotated result stream. W/TAG_W must match the attached block.
interface rc5_rotator_pipe_if #(
    parameter int W     = 32,
    parameter int TAG_W = 4
);
    localparam int LW = $clog2(W);

    logic             in_valid;
    logic             in_ready;
    logic             in_dir;
    logic [LW-1:0]    in_amt;
    logic [W-1:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    // slave is the rotator itself; master is whatever feeds and drains it.
    modport slave (
        input  in_valid, in_dir, in_amt, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_dir, in_amt, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/rc5_rotator_pipe.sv
// Fully pipelined W-bit rotator: one registered barrel stage per amount bit,
// right rotates folded into left rotates at the input, valid/ready on both sides.
module rc5_rotator_pipe #(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    rc5_rotator_pipe_if.slave bus
);
    localparam int LW = $clog2(W);

    logic             valid_q [LW];
    logic [W-1:0]     data_q  [LW];
    logic [LW-1:0]    amt_q   [LW];
    logic [TAG_W-1:0] tag_q   [LW];

    logic             valid_d [LW];
    logic [W-1:0]     data_d  [LW];
    logic [LW-1:0]    amt_d   [LW];
    logic [TAG_W-1:0] tag_d   [LW];

    logic             src_valid [LW];
    logic [W-1:0]     src_data  [LW];
    logic [LW-1:0]    src_amt   [LW];
    logic [TAG_W-1:0] src_tag   [LW];

    logic [LW-1:0]    adv;
    logic [LW-1:0]    eff_amt;

    // Ready chain: a stage may load if it is empty or the stage after it moves.
    always_comb begin : ready_chain
        logic chain;
        chain = bus.out_ready;
        for (int s = LW - 1; s >= 0; s--) begin
            chain  = !valid_q[s] || chain;
            adv[s] = chain;
        end
    end

    always_comb begin
        // (W - amt) mod W is just the LW-bit negation of amt.
        eff_amt = bus.in_dir ? ({LW{1'b0}} - bus.in_amt) : bus.in_amt;

        src_valid[0] = bus.in_valid;
        src_data[0]  = bus.in_data;
        src_amt[0]   = eff_amt;
        src_tag[0]   = bus.in_tag;
        for (int s = 1; s < LW; s++) begin
            src_valid[s] = valid_q[s-1];
            src_data[s]  = data_q[s-1];
            src_amt[s]   = amt_q[s-1];
            src_tag[s]   = tag_q[s-1];
        end

        for (int s = 0; s < LW; s++) begin
            valid_d[s] = src_valid[s];
            amt_d[s]   = src_amt[s];
            tag_d[s]   = src_tag[s];
            data_d[s]  = src_amt[s][s]
                       ? ((src_data[s] << (1 << s)) | (src_data[s] >> (W - (1 << s))))
                       : src_data[s];
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < LW; s++) begin
            if (rst) begin
                // NOTE: payload registers are cleared too, so out_data/out_tag read 0 after reset instead of stale words.
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                amt_q[s]   <= '0;
                tag_q[s]   <= '0;
            end else if (adv[s]) begin
                valid_q[s] <= valid_d[s];
                data_q[s]  <= data_d[s];
                amt_q[s]   <= amt_d[s];
                tag_q[s]   <= tag_d[s];
            end
        end
    end

    assign bus.in_ready  = adv[0] & !rst;
    assign bus.out_valid = valid_q[LW-1];
    assign bus.out_data  = data_q[LW-1];
    assign bus.out_tag   = tag_q[LW-1];
endmodule

// File: tb/tb_rc5_rotator_pipe.sv
// Directed bench for rc5_rotator_pipe: W=32 handshake/latency/stall/flush behaviour,
// plus W=64 and W=16 builds checked against an index-based rotate model.
module tb_rc5_rotator_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rc5_rotator_pipe_if #(.W(32), .TAG_W(4)) bus32 ();
    rc5_rotator_pipe_if #(.W(64), .TAG_W(4)) bus64 ();
    rc5_rotator_pipe_if #(.W(16), .TAG_W(4)) bus16 ();

    rc5_rotator_pipe #(.W(32), .TAG_W(4)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    rc5_rotator_pipe #(.W(64), .TAG_W(4)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
    rc5_rotator_pipe #(.W(16), .TAG_W(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    // Reference rotate: moves bit j to position (j + eff) mod w.
    function automatic logic [63:0] ref_rot(input logic [63:0] d, input int amt,
                                            input logic dir, input int w);
        logic [63:0] r;
        int e;
        r = '0;
        e = dir ? (w - amt) % w : amt;
        for (int j = 0; j < w; j++) r[(j + e) % w] = d[j];
        return r;
    endfunction

    task automatic idle_all();
        bus32.in_valid = 1'b0; bus32.in_dir = 1'b0; bus32.in_amt = '0;
        bus32.in_data = '0; bus32.in_tag = '0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_dir = 1'b0; bus64.in_amt = '0;
        bus64.in_data = '0; bus64.in_tag = '0; bus64.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_dir = 1'b0; bus16.in_amt = '0;
        bus16.in_data = '0; bus16.in_tag = '0; bus16.out_ready = 1'b1;
    endtask

    // Drives one word into an idle W=32 pipe and waits (bounded) for its result.
    task automatic send_one32(input logic dir, input logic [4:0] amt, input logic [31:0] data,
                              input logic [3:0] tag, output logic [31:0] got_data,
                              output logic [3:0] got_tag, output int lat);
        @(negedge clk);
        bus32.out_ready = 1'b1;
        bus32.in_valid = 1'b1; bus32.in_dir = dir; bus32.in_amt = amt;
        bus32.in_data = data; bus32.in_tag = tag;
        #1;
        checks++;
        if (bus32.in_ready !== 1'b1) begin
            errors++; $display("FAIL send32_in_ready: got %b expected 1", bus32.in_ready);
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        lat = 1;
        #1;
        while (bus32.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk); lat++; #1;
        end
        got_data = bus32.out_data;
        got_tag  = bus32.out_tag;
    endtask

    task automatic send_one64(input logic dir, input logic [5:0] amt, input logic [63:0] data,
                              output logic [63:0] got_data, output int lat);
        @(negedge clk);
        bus64.out_ready = 1'b1;
        bus64.in_valid = 1'b1; bus64.in_dir = dir; bus64.in_amt = amt;
        bus64.in_data = data; bus64.in_tag = 4'h6;
        @(negedge clk);
        bus64.in_valid = 1'b0;
        lat = 1;
        #1;
        while (bus64.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk); lat++; #1;
        end
        got_data = bus64.out_data;
    endtask

    task automatic send_one16(input logic dir, input logic [3:0] amt, input logic [15:0] data,
                              output logic [15:0] got_data, output int lat);
        @(negedge clk);
        bus16.out_ready = 1'b1;
        bus16.in_valid = 1'b1; bus16.in_dir = dir; bus16.in_amt = amt;
        bus16.in_data = data; bus16.in_tag = 4'h1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        lat = 1;
        #1;
        while (bus16.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk); lat++; #1;
        end
        got_data = bus16.out_data;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus32.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", bus32.in_ready);
        end
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus32.out_valid);
        end
        checks++;
        if (bus32.out_data !== 32'h0 || bus32.out_tag !== 4'h0) begin
            errors++; $display("FAIL reset_out_payload: got %h/%h expected 0/0",
                               bus32.out_data, bus32.out_tag);
        end
        checks++;
        if (bus64.out_valid !== 1'b0 || bus16.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_other_widths: got %b/%b expected 0/0",
                               bus64.out_valid, bus16.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus32.in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b expected 1", bus32.in_ready);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        send_one32(1'b0, 5'd1, 32'h8000_0001, 4'h3, d, t, lat);
        checks++;
        if (d !== 32'h0000_0003 || t !== 4'h3) begin
            errors++; $display("FAIL single_rol1: got %h/%h expected 00000003/3", d, t);
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL single_latency: got %0d expected 5", lat);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus32.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_one_cycle: got out_valid %b expected 0", bus32.out_valid);
        end
    endtask

    task automatic test_directed();
        logic        v_dir  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0]  v_amt  [5] = '{5'd4, 5'd0, 5'd0, 5'd31, 5'd1};
        logic [31:0] v_data [5] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                    32'h0000_0001, 32'h0000_0001};
        logic [31:0] v_exp  [5] = '{32'h8123_4567, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                    32'h8000_0000, 32'h8000_0000};
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            send_one32(v_dir[i], v_amt[i], v_data[i], 4'(i + 1), d, t, lat);
            checks++;
            if (d !== v_exp[i] || t !== 4'(i + 1) || lat !== 5) begin
                errors++; $display("FAIL directed_%0d: got %h/%h lat %0d expected %h/%h lat 5",
                                   i, d, t, lat, v_exp[i], 4'(i + 1));
            end
        end
    endtask

    // mode 0: out_ready low for the first 10 cycles; 1: random out_ready; 2: out_ready always 1.
    task automatic run_stream32(input int n, input int mode, output int acc10);
        logic [31:0] exp_d [$];
        logic [3:0]  exp_t [$];
        logic [63:0] m;
        logic [31:0] w_data, held_d;
        logic [3:0]  held_t;
        logic        held;
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0; held = 1'b0; acc10 = -1;
        held_d = '0; held_t = '0;
        @(negedge clk);
        while (recv < n && cyc < 2000) begin
            w_data = 32'h9E37_79B9 * 32'(sent + 1);
            bus32.in_valid = (sent < n);
            bus32.in_dir   = 1'(sent % 2);
            bus32.in_amt   = 5'(sent % 32);
            bus32.in_data  = w_data;
            bus32.in_tag   = 4'(sent);
            case (mode)
                0:       bus32.out_ready = (cyc >= 10);
                1:       bus32.out_ready = 1'($urandom_range(0, 1));
                default: bus32.out_ready = 1'b1;
            endcase
            #1;
            if (cyc == 10) acc10 = sent;
            if (mode == 2 && sent < n) begin
                checks++;
                if (bus32.in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", cyc, bus32.in_ready);
                end
            end
            if (mode == 0 && cyc >= 5 && cyc < 10) begin
                checks++;
                if (bus32.in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", cyc, bus32.in_ready);
                end
            end
            if (held) begin
                checks++;
                if (bus32.out_valid !== 1'b1 || bus32.out_data !== held_d || bus32.out_tag !== held_t) begin
                    errors++; $display("FAIL stall_hold cyc %0d: got %b %h/%h expected 1 %h/%h",
                                       cyc, bus32.out_valid, bus32.out_data, bus32.out_tag, held_d, held_t);
                end
            end
            if (mode == 2 && recv > 0) begin
                checks++;
                if (bus32.out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_gap cyc %0d: got out_valid %b expected 1", cyc, bus32.out_valid);
                end
            end
            if (bus32.out_valid === 1'b1 && bus32.out_ready === 1'b1) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL stream_extra cyc %0d: got %h expected no word", cyc, bus32.out_data);
                end else begin
                    if (bus32.out_data !== exp_d[0] || bus32.out_tag !== exp_t[0]) begin
                        errors++; $display("FAIL stream_word %0d: got %h/%h expected %h/%h",
                                           recv, bus32.out_data, bus32.out_tag, exp_d[0], exp_t[0]);
                    end
                    void'(exp_d.pop_front());
                    void'(exp_t.pop_front());
                end
                recv++;
            end
            if (bus32.in_valid === 1'b1 && bus32.in_ready === 1'b1) begin
                m = ref_rot({32'h0, w_data}, sent % 32, 1'(sent % 2), 32);
                exp_d.push_back(m[31:0]);
                exp_t.push_back(4'(sent));
                sent++;
            end
            held   = bus32.out_valid & !bus32.out_ready;
            held_d = bus32.out_data;
            held_t = bus32.out_tag;
            @(negedge clk);
            cyc++;
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        checks++;
        if (recv !== n || sent !== n) begin
            errors++; $display("FAIL stream_count: got %0d sent %0d received expected %0d", sent, recv, n);
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (bus32.out_valid !== 1'b0) begin
                errors++; $display("FAIL stream_drained: got out_valid %b expected 0", bus32.out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        run_stream32(64, 2, acc);
    endtask

    task automatic test_stall();
        int acc;
        run_stream32(12, 0, acc);
        checks++;
        if (acc !== 5) begin
            errors++; $display("FAIL stall_capacity: got %0d accepts expected 5", acc);
        end
        run_stream32(20, 1, acc);
    endtask

    task automatic test_reset_flush();
        int outs;
        @(negedge clk);
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus32.in_valid = 1'b1; bus32.in_dir = 1'b0; bus32.in_amt = 5'd4;
            bus32.in_data = 32'h1111_0000 + 32'(i); bus32.in_tag = 4'(10 + i);
            #1;
            checks++;
            if (bus32.in_ready !== 1'b1) begin
                errors++; $display("FAIL flush_fill_ready %0d: got %b expected 1", i, bus32.in_ready);
            end
            @(negedge clk);
        end
        bus32.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus32.in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready_rst: got %b expected 0", bus32.in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.out_data !== 32'h0 || bus32.out_tag !== 4'h0) begin
            errors++; $display("FAIL flush_cleared: got %b %h/%h expected 0 00000000/0",
                               bus32.out_valid, bus32.out_data, bus32.out_tag);
        end
        checks++;
        if (bus32.in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready_held: got %b expected 0", bus32.in_ready);
        end
        rst = 1'b0;
        bus32.in_valid = 1'b1; bus32.in_dir = 1'b0; bus32.in_amt = 5'd8;
        bus32.in_data = 32'h0000_00AB; bus32.in_tag = 4'h5;
        #1;
        checks++;
        if (bus32.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_release_ready: got %b expected 1", bus32.in_ready);
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        outs = 0;
        for (int k = 0; k < 15; k++) begin
            #1;
            if (bus32.out_valid === 1'b1) begin
                outs++;
                if (outs == 1) begin
                    checks++;
                    if (bus32.out_data !== 32'h0000_AB00 || bus32.out_tag !== 4'h5) begin
                        errors++; $display("FAIL flush_new_word: got %h/%h expected 0000ab00/5",
                                           bus32.out_data, bus32.out_tag);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (outs !== 1) begin
            errors++; $display("FAIL flush_no_ghosts: got %0d words expected 1", outs);
        end
    endtask

    task automatic test_widths();
        logic [63:0] d64, r64, m;
        logic [15:0] d16;
        logic [5:0]  a64;
        logic [3:0]  a16;
        logic        dir;
        int          lat;
        send_one64(1'b0, 6'd63, 64'h8000_0000_0000_0001, d64, lat);
        checks++;
        if (d64 !== 64'hC000_0000_0000_0000 || lat !== 6) begin
            errors++; $display("FAIL w64_rol63: got %h lat %0d expected c000000000000000 lat 6", d64, lat);
        end
        send_one64(1'b1, 6'd1, 64'h8000_0000_0000_0001, d64, lat);
        checks++;
        if (d64 !== 64'hC000_0000_0000_0000 || lat !== 6) begin
            errors++; $display("FAIL w64_ror1: got %h lat %0d expected c000000000000000 lat 6", d64, lat);
        end
        send_one16(1'b0, 4'd15, 16'h0001, d16, lat);
        checks++;
        if (d16 !== 16'h8000 || lat !== 4) begin
            errors++; $display("FAIL w16_rol15: got %h lat %0d expected 8000 lat 4", d16, lat);
        end
        send_one16(1'b1, 4'd4, 16'h1234, d16, lat);
        checks++;
        if (d16 !== 16'h4123 || lat !== 4) begin
            errors++; $display("FAIL w16_ror4: got %h lat %0d expected 4123 lat 4", d16, lat);
        end
        for (int i = 0; i < 8; i++) begin
            r64 = {$urandom, $urandom};
            a64 = 6'($urandom_range(0, 63));
            dir = 1'($urandom_range(0, 1));
            send_one64(dir, a64, r64, d64, lat);
            m = ref_rot(r64, int'(a64), dir, 64);
            checks++;
            if (d64 !== m || lat !== 6) begin
                errors++; $display("FAIL w64_rand %0d: got %h lat %0d expected %h lat 6", i, d64, lat, m);
            end
            a16 = 4'($urandom_range(0, 15));
            send_one16(dir, a16, r64[15:0], d16, lat);
            m = ref_rot({48'h0, r64[15:0]}, int'(a16), dir, 16);
            checks++;
            if (d16 !== m[15:0] || lat !== 4) begin
                errors++; $display("FAIL w16_rand %0d: got %h lat %0d expected %h lat 4", i, d16, lat, m[15:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_single();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_widths();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
